// File: rtl/CameraPackerTypes.sv
// Shared types and constants for the camera capture path.
// Contents: counter/word widths, queue word layout, tagged marker words
// (also imported by the frame uploader), capture FSM state encoding and
// small helpers used by the packer.
package CameraPackerTypes;

    localparam int unsigned CNT_W  = 11;
    localparam int unsigned WORD_W = 17;
    localparam int unsigned DROP_W = 16;
    localparam int unsigned BYTE_W = 8;

    // Queue word: tag=1 marks a control marker, tag=0 carries an RGB565 pixel.
    typedef struct packed {
        logic               tag;
        logic [2*BYTE_W-1:0] payload;
    } qword_t;

    localparam logic [WORD_W-1:0] MARKER_FRAME_START = 17'h10000;
    localparam logic [WORD_W-1:0] MARKER_ROW_START   = 17'h10001;
    localparam logic [WORD_W-1:0] MARKER_FRAME_END   = 17'h1FFFF;
    localparam logic [WORD_W-1:0] PAD_WORD           = 17'h00000;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_ROW  = 3'd1,
        ST_BYTE_HI   = 3'd2,
        ST_BYTE_LO   = 3'd3,
        ST_PAD_ROW   = 3'd4,
        ST_FRAME_END = 3'd5
    } state_t;

    // Saturating increment so row/col never wrap within a frame.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    function automatic qword_t pixel_word(input logic [BYTE_W-1:0] hi,
                                          input logic [BYTE_W-1:0] lo);
        qword_t w;
        w.tag     = 1'b0;
        w.payload = {hi, lo};
        return w;
    endfunction

endpackage

// File: rtl/camera_input_sync.sv
// Two-stage input register for the OV7670 parallel bus plus VSYNC/HREF
// edge pulses. Edges compare stage 1 against stage 2; the pulses, the HREF
// level and the data byte are registered once more so they stay aligned.
// Ports:
//   clk, reset            system clock, async active-high reset
//   i_vsync/i_href/i_data raw camera signals
//   o_href, o_data        aligned HREF level and data byte (from stage 1)
//   o_vsync_rise/fall     one-cycle VSYNC edge pulses
//   o_href_rise           one-cycle HREF rising-edge pulse
module camera_input_sync
    import CameraPackerTypes::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              i_vsync,
    input  logic              i_href,
    input  logic [BYTE_W-1:0] i_data,
    output logic              o_href,
    output logic [BYTE_W-1:0] o_data,
    output logic              o_vsync_rise,
    output logic              o_vsync_fall,
    output logic              o_href_rise
);

    logic              r_vsync_s1;
    logic              r_vsync_s2;
    logic              r_href_s1;
    logic              r_href_s2;
    logic [BYTE_W-1:0] r_data_s1;

    // Synchronizer stages and aligned edge/level outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_vsync_s1   <= 1'b0;
            r_vsync_s2   <= 1'b0;
            r_href_s1    <= 1'b0;
            r_href_s2    <= 1'b0;
            r_data_s1    <= '0;
            o_href       <= 1'b0;
            o_data       <= '0;
            o_vsync_rise <= 1'b0;
            o_vsync_fall <= 1'b0;
            o_href_rise  <= 1'b0;
        end else begin
            r_vsync_s1   <= i_vsync;
            r_vsync_s2   <= r_vsync_s1;
            r_href_s1    <= i_href;
            r_href_s2    <= r_href_s1;
            r_data_s1    <= i_data;
            o_href       <= r_href_s1;
            o_data       <= r_data_s1;
            o_vsync_rise <= r_vsync_s1 & ~r_vsync_s2;
            o_vsync_fall <= ~r_vsync_s1 & r_vsync_s2;
            o_href_rise  <= r_href_s1 & ~r_href_s2;
        end
    end

endmodule

// File: rtl/camera_pixel_packer.sv
// Packs OV7670 byte pairs into RGB565 pixels and writes a tagged 17-bit
// word stream (frame start, row start per row, FRAME_WIDTH pixels per row,
// frame end) into the frame queue. Short rows are padded with zero words,
// surplus rows/pixels are dropped, and geometry faults raise frame_error.
// Ports:
//   clk, reset     system clock, async active-high reset
//   capture_en     arms capture, sampled only at frame start
//   cam_vsync/cam_href/cam_data  camera parallel bus
//   queue_full     queue back-pressure; words emitted while high are lost
//   queue_wr_en    one-cycle write strobe, queue_data tagged word
//   frame_active   high from the frame-start write to the frame-end write
//   frame_error    sticky geometry error, cleared at frame start
//   overflow       sticky lost-word flag, cleared at frame start
//   dropped_count  (only with DROP_COUNTER_EN) saturating lost-word count
// Build option: define DROP_COUNTER_EN to add dropped_count.
module camera_pixel_packer
    import CameraPackerTypes::*;
#(
    parameter int unsigned FRAME_WIDTH  = 640,
    parameter int unsigned FRAME_HEIGHT = 480
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              capture_en,
    input  logic              cam_vsync,
    input  logic              cam_href,
    input  logic [BYTE_W-1:0] cam_data,
    input  logic              queue_full,
    output logic              queue_wr_en,
    output logic [WORD_W-1:0] queue_data,
    output logic              frame_active,
    output logic              frame_error,
    output logic              overflow
`ifdef DROP_COUNTER_EN
    ,
    output logic [DROP_W-1:0] dropped_count
`endif
);

    localparam logic [CNT_W-1:0] LP_WIDTH  = CNT_W'(FRAME_WIDTH);
    localparam logic [CNT_W-1:0] LP_HEIGHT = CNT_W'(FRAME_HEIGHT);

    logic              w_href;
    logic [BYTE_W-1:0] w_data;
    logic              w_vsync_rise;
    logic              w_vsync_fall;
    logic              w_href_rise;

    state_t            r_state;
    logic [CNT_W-1:0]  r_row;
    logic [CNT_W-1:0]  r_col;
    logic [BYTE_W-1:0] r_hi;
    logic              r_wr_en;
    qword_t            r_data;
    logic              r_active;
    logic              r_error;
    logic              r_overflow;

    state_t            w_state_nxt;
    logic [CNT_W-1:0]  w_row_nxt;
    logic [CNT_W-1:0]  w_col_nxt;
    logic [BYTE_W-1:0] w_hi_nxt;
    logic              w_wr_en_nxt;
    qword_t            w_data_nxt;
    logic              w_active_nxt;
    logic              w_error_nxt;
    logic              w_overflow_nxt;
    logic              w_emit;
    qword_t            w_word;
    logic              w_row_end;

`ifdef DROP_COUNTER_EN
    logic [DROP_W-1:0] r_drop;
    logic [DROP_W-1:0] w_drop_nxt;
`endif

    camera_input_sync u_sync (
        .clk          (clk),
        .reset        (reset),
        .i_vsync      (cam_vsync),
        .i_href       (cam_href),
        .i_data       (cam_data),
        .o_href       (w_href),
        .o_data       (w_data),
        .o_vsync_rise (w_vsync_rise),
        .o_vsync_fall (w_vsync_fall),
        .o_href_rise  (w_href_rise)
    );

    // Next-state and output logic for the capture FSM.
    always_comb begin
        w_state_nxt    = r_state;
        w_row_nxt      = r_row;
        w_col_nxt      = r_col;
        w_hi_nxt       = r_hi;
        w_wr_en_nxt    = 1'b0;
        w_data_nxt     = r_data;
        w_active_nxt   = (r_state != ST_IDLE);
        w_error_nxt    = r_error;
        w_overflow_nxt = r_overflow;
        w_emit         = 1'b0;
        w_word         = qword_t'(PAD_WORD);
        w_row_end      = 1'b0;
`ifdef DROP_COUNTER_EN
        w_drop_nxt     = r_drop;
`endif

        case (r_state)
            ST_IDLE: begin
                if (w_vsync_fall && capture_en) begin
                    w_emit         = 1'b1;
                    w_word         = qword_t'(MARKER_FRAME_START);
                    w_row_nxt      = '0;
                    w_col_nxt      = '0;
                    w_error_nxt    = 1'b0;
                    w_overflow_nxt = 1'b0;
                    w_active_nxt   = 1'b1;
`ifdef DROP_COUNTER_EN
                    w_drop_nxt     = '0;
`endif
                    w_state_nxt    = ST_WAIT_ROW;
                end
            end

            ST_WAIT_ROW: begin
                if (w_vsync_rise) begin
                    w_state_nxt = ST_FRAME_END;
                end else if (w_href_rise) begin
                    if (r_row < LP_HEIGHT) begin
                        w_emit      = 1'b1;
                        w_word      = qword_t'(MARKER_ROW_START);
                        w_hi_nxt    = w_data;
                        w_col_nxt   = '0;
                        w_state_nxt = ST_BYTE_LO;
                    end else begin
                        // Surplus row: ignored entirely.
                        w_error_nxt = 1'b1;
                    end
                end
            end

            ST_BYTE_HI: begin
                if (w_vsync_rise) begin
                    w_row_nxt   = sat_inc(r_row);
                    w_error_nxt = 1'b1;
                    w_state_nxt = ST_FRAME_END;
                end else if (w_href) begin
                    w_hi_nxt    = w_data;
                    w_state_nxt = ST_BYTE_LO;
                end else begin
                    w_row_end = 1'b1;
                end
            end

            ST_BYTE_LO: begin
                if (w_vsync_rise) begin
                    w_row_nxt   = sat_inc(r_row);
                    w_error_nxt = 1'b1;
                    w_state_nxt = ST_FRAME_END;
                end else if (w_href) begin
                    if (r_col < LP_WIDTH) begin
                        w_emit    = 1'b1;
                        w_word    = pixel_word(r_hi, w_data);
                        w_col_nxt = sat_inc(r_col);
                    end else begin
                        w_error_nxt = 1'b1;
                    end
                    w_state_nxt = ST_BYTE_HI;
                end else begin
                    // Row ended on an unpaired high byte.
                    w_error_nxt = 1'b1;
                    w_row_end   = 1'b1;
                end
            end

            ST_PAD_ROW: begin
                if (w_vsync_rise) begin
                    w_row_nxt   = sat_inc(r_row);
                    w_error_nxt = 1'b1;
                    w_state_nxt = ST_FRAME_END;
                end else begin
                    w_emit    = 1'b1;
                    w_word    = qword_t'(PAD_WORD);
                    w_col_nxt = sat_inc(r_col);
                    if (sat_inc(r_col) >= LP_WIDTH) begin
                        w_state_nxt = ST_WAIT_ROW;
                    end
                    // A row starting mid-pad is lost; WAIT_ROW only reacts to a fresh rise.
                    if (w_href_rise) begin
                        w_error_nxt = 1'b1;
                    end
                end
            end

            ST_FRAME_END: begin
                w_emit = 1'b1;
                w_word = qword_t'(MARKER_FRAME_END);
                if (r_row < LP_HEIGHT) begin
                    w_error_nxt = 1'b1;
                end
                w_state_nxt = ST_IDLE;
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Row completion shared by BYTE_HI and BYTE_LO.
        if (w_row_end) begin
            w_row_nxt = sat_inc(r_row);
            if (r_col < LP_WIDTH) begin
                w_error_nxt = 1'b1;
                w_state_nxt = ST_PAD_ROW;
            end else begin
                w_state_nxt = ST_WAIT_ROW;
            end
        end

        // Queue write; a full queue loses the word but counters still advance.
        if (w_emit) begin
            w_data_nxt = w_word;
            if (queue_full) begin
                w_overflow_nxt = 1'b1;
`ifdef DROP_COUNTER_EN
                if (w_drop_nxt != {DROP_W{1'b1}}) begin
                    w_drop_nxt = w_drop_nxt + DROP_W'(1);
                end
`endif
            end else begin
                w_wr_en_nxt = 1'b1;
            end
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_row      <= '0;
            r_col      <= '0;
            r_hi       <= '0;
            r_wr_en    <= 1'b0;
            r_data     <= '0;
            r_active   <= 1'b0;
            r_error    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_row      <= w_row_nxt;
            r_col      <= w_col_nxt;
            r_hi       <= w_hi_nxt;
            r_wr_en    <= w_wr_en_nxt;
            r_data     <= w_data_nxt;
            r_active   <= w_active_nxt;
            r_error    <= w_error_nxt;
            r_overflow <= w_overflow_nxt;
        end
    end

`ifdef DROP_COUNTER_EN
    // Saturating lost-word counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_drop <= '0;
        end else begin
            r_drop <= w_drop_nxt;
        end
    end

    assign dropped_count = r_drop;
`endif

    assign queue_wr_en  = r_wr_en;
    assign queue_data   = r_data;
    assign frame_active = r_active;
    assign frame_error  = r_error;
    assign overflow     = r_overflow;

endmodule
